// File: rtl/alu_pkg.sv
// alu_pkg: opsel codes and FSM state encodings shared by the ALU execution unit
package alu_pkg;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
endpackage

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter: one-bit-per-cycle shifter; done marks the edge that produces the final value on nxt
module alu_serial_shifter #(
  parameter int XLEN = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [XLEN-1:0]    din,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               left,
  input  logic               arith,
  output logic               done,
  output logic [XLEN-1:0]    nxt
);
  logic [XLEN-1:0] acc;
  logic [SHAMT_W-1:0] cnt;
  logic left_q, arith_q;
  assign nxt = left_q ? {acc[XLEN-2:0], 1'b0} : {arith_q & acc[XLEN-1], acc[XLEN-1:1]};
  assign done = cnt == SHAMT_W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      left_q <= 1'b0;
      arith_q <= 1'b0;
    end else if (start) begin
      acc <= din;
      cnt <= shamt;
      left_q <= left;
      arith_q <= arith;
    end else if (cnt != '0) begin
      acc <= nxt;
      cnt <= cnt - SHAMT_W'(1);
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU execute stage with valid/ready result handshake; ALU_FAST_SHIFT_EN selects a barrel shifter over the serial one
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic [2:0]      i_opsel,
  input  logic            i_sub,
  input  logic            i_unsigned,
  input  logic            i_arith,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic            o_ovf
);
  logic [1:0] state;
  logic [XLEN-1:0] b, sum, sh_res, res;
  logic [SHAMT_W-1:0] shamt;
  logic lt, ovf, is_sh, accept;
  assign o_ready = state == S_IDLE;
  assign o_valid = state == S_DONE;
  assign accept = i_valid && o_ready;
  assign shamt = i_op2[SHAMT_W-1:0];
  assign is_sh = i_opsel == OP_SLL || i_opsel == OP_SRL;
  assign b = i_sub ? ~i_op2 : i_op2;
  assign sum = i_op1 + b + XLEN'(i_sub);
  assign lt = i_unsigned ? i_op1 < i_op2 : $signed(i_op1) < $signed(i_op2);
  assign ovf = i_arith && i_opsel == OP_ADD && i_op1[XLEN-1] == b[XLEN-1] && sum[XLEN-1] != i_op1[XLEN-1];
`ifdef ALU_FAST_SHIFT_EN
  logic [XLEN-1:0] sra_v;
  assign sra_v = $signed(i_op1) >>> shamt;
  assign sh_res = i_opsel == OP_SLL ? i_op1 << shamt : i_sub ? sra_v : i_op1 >> shamt;
`else
  logic sh_done;
  logic [XLEN-1:0] sh_nxt;
  logic go_shift;
  assign sh_res = i_op1;
  assign go_shift = accept && is_sh && shamt != '0;
  alu_serial_shifter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shift (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .start(go_shift),
    .din(i_op1),
    .shamt(shamt),
    .left(i_opsel == OP_SLL),
    .arith(i_sub),
    .done(sh_done),
    .nxt(sh_nxt)
  );
`endif
  always_comb begin
    res = sh_res;
    case (i_opsel)
      OP_ADD: res = sum;
      OP_SLT, OP_SLTU: res = {{(XLEN-1){1'b0}}, lt};
      OP_XOR: res = i_op1 ^ i_op2;
      OP_OR: res = i_op1 | i_op2;
      OP_AND: res = i_op1 & i_op2;
      default: res = sh_res;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= S_IDLE;
      o_result <= '0;
      o_zero <= 1'b0;
      o_ovf <= 1'b0;
    end else
      case (state)
        S_IDLE:
          if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
            if (go_shift) state <= S_SHIFT;
            else begin
`endif
              state <= S_DONE;
              o_result <= res;
              o_zero <= res == '0;
              o_ovf <= ovf;
`ifndef ALU_FAST_SHIFT_EN
            end
`endif
          end
`ifndef ALU_FAST_SHIFT_EN
        S_SHIFT:
          if (sh_done) begin
            state <= S_DONE;
            o_result <= sh_nxt;
            o_zero <= sh_nxt == '0;
            o_ovf <= 1'b0;
          end
`endif
        S_DONE: if (i_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and random checks of alu_exec_unit against an arithmetic reference model
module tb_alu_exec_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_valid = 1'b0, i_ready = 1'b1, i_sub = 1'b0, i_unsigned = 1'b0, i_arith = 1'b0;
  logic [31:0] i_op1 = '0, i_op2 = '0;
  logic [2:0] i_opsel = '0;
  logic o_ready, o_valid, o_zero, o_ovf;
  logic [31:0] o_result;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  alu_exec_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op1(i_op1), .i_op2(i_op2), .i_opsel(i_opsel), .i_sub(i_sub),
    .i_unsigned(i_unsigned), .i_arith(i_arith), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_zero(o_zero), .o_ovf(o_ovf)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                        input logic sub, input logic uns, input logic ar);
    int n;
    longint s;
    logic [31:0] r, mask;
    logic v;
    n = int'(b[4:0]);
    v = 1'b0;
    mask = 32'hFFFF_FFFF;
    case (op)
      3'd0: begin
        r = sub ? a - b : a + b;
        s = sub ? longint'($signed(a)) - longint'($signed(b)) : longint'($signed(a)) + longint'($signed(b));
        v = ar && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      3'd1: r = a << n;
      3'd2, 3'd3: r = {31'b0, uns ? a < b : $signed(a) < $signed(b)};
      3'd4: r = a ^ b;
      3'd5: r = (a >> n) | ((sub && a[31]) ? ~(mask >> n) : 32'h0);
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return {v, r};
  endfunction
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic sub, input logic uns, input logic ar);
    logic [32:0] m;
    int lat, cyc;
    m = model(a, b, op, sub, uns, ar);
`ifdef ALU_FAST_SHIFT_EN
    lat = 1;
`else
    lat = ((op == 3'd1 || op == 3'd5) && b[4:0] != 5'd0) ? int'(b[4:0]) + 1 : 1;
`endif
    @(negedge clk);
    check({tag, ".ready"}, 32'(o_ready), 32'd1);
    i_op1 = a; i_op2 = b; i_opsel = op; i_sub = sub; i_unsigned = uns; i_arith = ar; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    cyc = 1;
    while (!o_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".lat"}, 32'(cyc), 32'(lat));
    check({tag, ".res"}, o_result, m[31:0]);
    check({tag, ".zero"}, 32'(o_zero), 32'(m[31:0] == 32'h0));
    check({tag, ".ovf"}, 32'(o_ovf), 32'(m[32]));
    if (i_ready) begin
      @(posedge clk); #1;
      check({tag, ".drop"}, 32'(o_valid), 32'd0);
    end
  endtask
  initial begin
    logic [31:0] held;
    #12;
    check("rst.valid", 32'(o_valid), 32'd0);
    check("rst.result", o_result, 32'd0);
    check("rst.zero", 32'(o_zero), 32'd0);
    check("rst.ovf", 32'(o_ovf), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("rst.ready", 32'(o_ready), 32'd1);
    run_op("add", 32'd5, 32'd7, 3'd0, 1'b0, 1'b0, 1'b0);
    run_op("sub0", 32'd9, 32'd9, 3'd0, 1'b1, 1'b0, 1'b0);
    run_op("ovf", 32'h7FFF_FFFF, 32'd1, 3'd0, 1'b0, 1'b0, 1'b1);
    run_op("subovf", 32'h8000_0000, 32'd1, 3'd0, 1'b1, 1'b0, 1'b1);
    run_op("noarith", 32'h7FFF_FFFF, 32'd1, 3'd0, 1'b0, 1'b0, 1'b0);
    run_op("sra4", 32'h8000_0000, 32'd4, 3'd5, 1'b1, 1'b0, 1'b0);
    run_op("srl4", 32'h8000_0000, 32'd4, 3'd5, 1'b0, 1'b0, 1'b0);
    run_op("sll0", 32'hDEAD_BEEF, 32'd0, 3'd1, 1'b0, 1'b0, 1'b0);
    run_op("sll31", 32'h0000_0003, 32'd31, 3'd1, 1'b0, 1'b0, 1'b0);
    run_op("slt", 32'd1, 32'hFFFF_FFFF, 3'd2, 1'b0, 1'b0, 1'b0);
    run_op("sltu", 32'd1, 32'hFFFF_FFFF, 3'd3, 1'b0, 1'b1, 1'b0);
    run_op("xor", 32'hF0F0_1234, 32'h0FF0_FFFF, 3'd4, 1'b0, 1'b0, 1'b0);
    run_op("or", 32'hF000_0000, 32'h0000_000F, 3'd6, 1'b0, 1'b0, 1'b0);
    run_op("and", 32'hFF00_FF00, 32'h0FF0_0FF0, 3'd7, 1'b0, 1'b0, 1'b0);
    i_ready = 1'b0;
    run_op("hold", 32'd100, 32'd23, 3'd0, 1'b0, 1'b0, 1'b0);
    held = 32'd123;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_op1 = $urandom; i_op2 = $urandom; i_opsel = 3'd4; i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      check("hold.valid", 32'(o_valid), 32'd1);
      check("hold.ready", 32'(o_ready), 32'd0);
      check("hold.result", o_result, held);
    end
    @(negedge clk); i_ready = 1'b1;
    @(posedge clk); #1;
    check("hold.drop", 32'(o_valid), 32'd0);
    check("hold.idle", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    check("hold.noqueue", 32'(o_valid), 32'd0);
    @(negedge clk);
    i_ready = 1'b0;
    i_op1 = 32'hABCD_1234; i_op2 = 32'd20; i_opsel = 3'd5; i_sub = 1'b0; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.valid", 32'(o_valid), 32'd0);
    check("midrst.result", o_result, 32'd0);
    check("midrst.ovf", 32'(o_ovf), 32'd0);
    @(negedge clk); rst_n = 1'b1; i_ready = 1'b1;
    #1 check("midrst.ready", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    check("midrst.novalid", 32'(o_valid), 32'd0);
    run_op("postrst", 32'd40, 32'd2, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++)
      run_op("rand", $urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
